tx_serial_fsm: RTL and testbench

// - Free-running parallel-to-serial transmitter with a programmable bit-rate divisor.
// - Repeatedly captures data_i and shifts it out MSB first on data_o.
// - ena_o marks the cycles where data_o carries a valid bit.
// - Leaf block between a register/data source and a serial pin; there is no start handshake.

---
 rtl/tx_serial_fsm.sv | 127 ++++++++++++
 tb/tb_tx_serial_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tx_serial_fsm.sv
// Free-running parallel-to-serial transmitter: captures data_i each frame and shifts it out MSB first.
// Optional even-parity bit after the data word when TX_SERIAL_PARITY_EN is defined.
module tx_serial_fsm #(
    parameter int DW  = 8,
    parameter int DVW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DW-1:0]  data_i,
    input  logic [DVW-1:0] dvsr_i,
    output logic           data_o,
    output logic           ena_o
);

`ifdef TX_SERIAL_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_GAP   = 2'b11
    } state_t;

    function automatic logic even_parity(input logic [DW-1:0] d);
        return ^d;
    endfunction

    function automatic logic [NB-1:0] frame_word(input logic [DW-1:0] d);
`ifdef TX_SERIAL_PARITY_EN
        return {d, even_parity(d)};
`else
        return d;
`endif
    endfunction

    state_t          r_state;
    logic [NB-2:0]   r_shreg;
    logic [DVW-1:0]  r_dq;
    logic [DVW-1:0]  r_tick;
    logic [BW-1:0]   r_bit;
    logic            r_data_o;
    logic            r_ena_o;

    logic [NB-1:0]   w_frame;
    logic            w_tick_end;
    logic            w_last_bit;

    // Frame word and end-of-bit / end-of-frame decodes.
    always_comb begin
        w_frame    = frame_word(data_i);
        w_tick_end = (r_tick == r_dq);
        w_last_bit = (r_bit == BW'(NB - 1));
    end

    // r_shreg holds only the bits not yet on the pin; the current bit lives in r_data_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_dq     <= '0;
            r_tick   <= '0;
            r_bit    <= '0;
            r_data_o <= 1'b0;
            r_ena_o  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_LOAD;
                    r_data_o <= 1'b0;
                    r_ena_o  <= 1'b0;
                end
                S_LOAD: begin
                    r_shreg  <= w_frame[NB-2:0];
                    r_dq     <= dvsr_i;
                    r_tick   <= '0;
                    r_bit    <= '0;
                    r_data_o <= w_frame[NB-1];
                    r_ena_o  <= 1'b1;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_tick_end) begin
                        r_tick <= '0;
                        if (w_last_bit) begin
                            r_bit    <= '0;
                            r_data_o <= 1'b0;
                            r_ena_o  <= 1'b0;
                            r_state  <= S_GAP;
                        end else begin
                            r_bit    <= r_bit + BW'(1);
                            r_data_o <= r_shreg[NB-2];
                            r_shreg  <= {r_shreg[NB-3:0], 1'b0};
                            r_ena_o  <= 1'b1;
                        end
                    end else begin
                        r_tick  <= r_tick + DVW'(1);
                        r_ena_o <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_data_o <= 1'b0;
                    r_ena_o  <= 1'b0;
                    if (w_tick_end) begin
                        r_tick  <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_tick <= r_tick + DVW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_data_o <= 1'b0;
                    r_ena_o  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o = r_data_o;
    assign ena_o  = r_ena_o;

endmodule

// File: tb/tb_tx_serial_fsm.sv
// Scoreboard bench for tx_serial_fsm: per-frame expected bits with cycle stamps, checked by a monitor.
module tb_tx_serial_fsm;

    logic        clk;
    logic        rst_i;
    logic [7:0]  data_i;
    logic [15:0] dvsr_i;
    logic        data_o;
    logic        ena_o;

    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   tests;
    int   fails;
    exp_t m_e;

    tx_serial_fsm #(.DW(8), .DVW(16)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .data_i (data_i),
        .dvsr_i (dvsr_i),
        .data_o (data_o),
        .ena_o  (ena_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with ena_o high must match the oldest pending expected bit and its cycle.
    always @(negedge clk) begin
        if (ena_o === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_bit: cycle %0d got ena_o=1 data_o=%b, required ena_o=0", cyc, data_o);
            end else begin
                m_e = q.pop_front();
                if (m_e.cyc != cyc || data_o !== m_e.b) begin
                    fails++;
                    $display("FAIL serial_bit: got data_o=%b at cycle %0d, required data_o=%b at cycle %0d",
                             data_o, cyc, m_e.b, m_e.cyc);
                end
            end
        end else begin
            tests++;
            if (data_o !== 1'b0 || ena_o !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs: cycle %0d got data_o=%b ena_o=%b, required 0/0", cyc, data_o, ena_o);
            end
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_bit: cycle %0d got ena_o=0, required bit %b due at cycle %0d",
                         cyc, q[0].b, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    // Called just after a negedge, one cycle before the LOAD edge that captures d/v.
    task automatic run_frame(input logic [7:0] d, input int v, input int abort_at);
        logic bits[$];
        int   per;
        int   p;
        int   k;
        int   c;
        exp_t e;
        per = v + 1;
        for (int i = 7; i >= 0; i--) bits.push_back(((d >> i) & 8'd1) != 8'd0);
`ifdef TX_SERIAL_PARITY_EN
        bits.push_back(($countones(d) % 2) == 1);
`endif
        p = 1 + (bits.size() + 1) * per;
        data_i = d;
        dvsr_i = 16'(v);
        k = cyc + 1;
        for (int i = 0; i < bits.size(); i++) begin
            for (int j = 0; j < per; j++) begin
                e.cyc = k + i * per + j;
                e.b   = bits[i];
                q.push_back(e);
            end
        end
        for (int t = 1; t < p; t++) begin
            @(negedge clk); #1;
            if (abort_at != 0 && t == abort_at) begin
                rst_i = 1'b1;
                c = cyc;
                while (q.size() > 0 && q[q.size()-1].cyc >= c + 1) void'(q.pop_back());
                repeat (3) begin
                    @(negedge clk); #1;
                    data_i = 8'($urandom);
                end
                rst_i = 1'b0;
                @(negedge clk); #1;
                return;
            end
            data_i = 8'($urandom);
            dvsr_i = 16'($urandom);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_i  = 1'b1;
        data_i = 8'($urandom);
        dvsr_i = 16'($urandom);
        repeat (3) begin
            @(negedge clk); #1;
            data_i = 8'($urandom);
            dvsr_i = 16'($urandom);
        end
        rst_i = 1'b0;
        @(negedge clk); #1;

        run_frame(8'hA5, 3, 0);
        run_frame(8'hA5, 3, 0);
        run_frame(8'hFF, 0, 0);
        run_frame(8'h00, 0, 0);
        run_frame(8'h3C, 2, 0);
        run_frame(8'hC3, 5, 0);
        run_frame(8'h07, 1, 0);
        run_frame(8'h96, 3, 17);
        run_frame(8'h96, 3, 0);
        run_frame(8'h81, 300, 0);
        for (int n = 0; n < 24; n++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 4)), 0);
        end
        run_frame(8'h5A, 2, 5);
        run_frame(8'($urandom), 1, 0);

        for (int w = 0; w < 1000 && q.size() > 0; w++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending bits at end, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
